// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone SDRAM arbiter.
//   arb_state_t : arbiter FSM states (IDLE, BUSY, ABORT)
//   wb_sel_w()  : byte-select width for a given data width
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } arb_state_t;

    // One SEL bit per byte lane.
    function automatic int wb_sel_w(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// Combinational round-robin picker.
//   req_i   : N request bits
//   last_i  : index of the previous owner; search starts at last_i+1 and wraps
//   gnt_o   : one-hot winner (all zero when nobody requests)
//   idx_o   : binary index of the winner
//   valid_o : at least one request present
module wb_rr_picker #(
    parameter int N  = 2,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] last_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o,
    output logic          valid_o
);

    int            sum_s;
    logic [PW-1:0] cand_s;
    logic          hit_s;

    // Walk candidates last+1 .. last+N (mod N); the first requester wins.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        sum_s   = 0;
        cand_s  = '0;
        hit_s   = 1'b0;
        for (int k = 1; k <= N; k++) begin
            sum_s          = int'(last_i) + k;
            sum_s          = (sum_s >= N) ? (sum_s - N) : sum_s;
            cand_s         = PW'(sum_s);
            hit_s          = req_i[cand_s] & ~valid_o;
            gnt_o[cand_s]  = gnt_o[cand_s] | hit_s;
            idx_o          = hit_s ? cand_s : idx_o;
            valid_o        = valid_o | hit_s;
        end
    end

endmodule

// File: rtl/wb_sdram_arbiter.sv
// Round-robin arbiter sharing one Wishbone B4 classic slave (the SDRAM
// controller) between N_MASTERS masters. Ownership spans a whole CYC frame,
// one idle cycle separates owners, and a watchdog aborts a strobe that waits
// TIMEOUT cycles without ACK.
//   wb_clk_i / wb_rst_i : clock, asynchronous active-low reset
//   m_*_i / m_*_o       : packed per-master Wishbone signals (master k at slice k)
//   s_*_o / s_*_i       : single slave-side Wishbone port
//   gnt_o               : one-hot current owner, zero while idle
module wb_sdram_arbiter
    import wb_arb_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int TIMEOUT   = 64
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic [N_MASTERS-1:0]        m_cyc_i,
    input  logic [N_MASTERS-1:0]        m_stb_i,
    input  logic [N_MASTERS-1:0]        m_we_i,
    input  logic [N_MASTERS*DW/8-1:0]   m_sel_i,
    input  logic [N_MASTERS*AW-1:0]     m_adr_i,
    input  logic [N_MASTERS*DW-1:0]     m_dat_i,
    output logic [DW-1:0]               m_dat_o,
    output logic [N_MASTERS-1:0]        m_ack_o,
    output logic [N_MASTERS-1:0]        m_err_o,
    output logic                        s_cyc_o,
    output logic                        s_stb_o,
    output logic                        s_we_o,
    output logic [DW/8-1:0]             s_sel_o,
    output logic [AW-1:0]               s_adr_o,
    output logic [DW-1:0]               s_dat_o,
    input  logic [DW-1:0]               s_dat_i,
    input  logic                        s_ack_i,
    output logic [N_MASTERS-1:0]        gnt_o
);

    localparam int SW   = wb_sel_w(DW);
    localparam int PW   = $clog2(N_MASTERS);
    localparam int WD_W = $clog2(TIMEOUT);

    arb_state_t            state_q, state_d;
    logic [N_MASTERS-1:0]  gnt_q, gnt_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic [WD_W-1:0]       wdog_q, wdog_d;

    logic [N_MASTERS-1:0]  pick_gnt_s;
    logic [PW-1:0]         pick_idx_s;
    logic                  pick_valid_s;
    logic                  stall_s;
    logic                  timeout_s;

    logic [SW-1:0]         sel_arr_s [N_MASTERS];
    logic [AW-1:0]         adr_arr_s [N_MASTERS];
    logic [DW-1:0]         dat_arr_s [N_MASTERS];

    // Unpack the flat per-master buses so the owner index selects directly.
    for (genvar k = 0; k < N_MASTERS; k++) begin : g_unpack
        assign sel_arr_s[k] = m_sel_i[k*SW +: SW];
        assign adr_arr_s[k] = m_adr_i[k*AW +: AW];
        assign dat_arr_s[k] = m_dat_i[k*DW +: DW];
    end

    wb_rr_picker #(
        .N  (N_MASTERS),
        .PW (PW)
    ) u_picker (
        .req_i   (m_cyc_i),
        .last_i  (ptr_q),
        .gnt_o   (pick_gnt_s),
        .idx_o   (pick_idx_s),
        .valid_o (pick_valid_s)
    );

    assign gnt_o     = gnt_q;
    // The pointer always holds the current owner while BUSY/ABORT.
    assign stall_s   = s_stb_o & ~s_ack_i;
    assign timeout_s = stall_s & (wdog_q == WD_W'(TIMEOUT - 1));

    // Slave-side mux and master-side return path; everything is zero outside BUSY.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        m_dat_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        if (state_q == BUSY) begin
            s_cyc_o = m_cyc_i[ptr_q];
            s_stb_o = m_stb_i[ptr_q] & m_cyc_i[ptr_q];
            s_we_o  = m_we_i[ptr_q];
            s_sel_o = sel_arr_s[ptr_q];
            s_adr_o = adr_arr_s[ptr_q];
            s_dat_o = dat_arr_s[ptr_q];
            m_dat_o = s_dat_i;
            m_ack_o = (s_ack_i & s_stb_o) ? gnt_q : '0;
            m_err_o = timeout_s ? gnt_q : '0;
        end else begin
            s_cyc_o = 1'b0;
        end
    end

    // Next-state logic for the FSM, owner pointer and watchdog.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        wdog_d  = '0;
        case (state_q)
            IDLE: begin
                if (pick_valid_s) begin
                    state_d = BUSY;
                    gnt_d   = pick_gnt_s;
                    ptr_d   = pick_idx_s;
                end else begin
                    gnt_d   = '0;
                end
            end
            BUSY: begin
                if (!m_cyc_i[ptr_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end else if (timeout_s) begin
                    state_d = ABORT;
                end else if (stall_s) begin
                    wdog_d  = wdog_q + WD_W'(1);
                end else begin
                    wdog_d  = '0;
                end
            end
            ABORT: begin
                // Hold the owner off the bus until it gives up its cycle.
                if (!m_cyc_i[ptr_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end else begin
                    state_d = ABORT;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State registers; the pointer resets to the last master so master 0 wins first.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= PW'(N_MASTERS - 1);
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            wdog_q  <= wdog_d;
        end
    end

endmodule
